// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam logic [8:0] HALT_CODE = 9'b111111111;
endpackage

// File: rtl/fetch_sequencer_pc_next_calc.sv
// Next-PC arithmetic: absolute branch, signed relative branch or sequential step, all modulo 2**D.
module pc_next_calc #(
    parameter int D    = 12,
    parameter int OFFW = 8
) (
    input  logic [D-1:0]    pc,
    input  logic            taken,
    input  logic            abs,
    input  logic [D-1:0]    target,
    input  logic [OFFW-1:0] offset,
    output logic [D-1:0]    next_pc
);
    logic [D-1:0] offset_ext;

    // Sign-extend to D bits; the D-bit sum drops the carry, giving the required wrap.
    assign offset_ext = {{(D-OFFW){offset[OFFW-1]}}, offset};

    always_comb begin
        if (taken && abs) begin
            next_pc = target;
        end else if (taken) begin
            next_pc = pc + offset_ext;
        end else begin
            next_pc = pc + D'(1);
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: owns the PC, fetches from a combinational ROM, and counts retired instructions.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int           D          = 12,
    parameter logic [D-1:0] START_ADDR = '0,
    parameter int           OFFW       = 8,
    parameter int           CNTW       = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic            branch_abs,
    input  logic [D-1:0]    branch_target,
    input  logic [OFFW-1:0] branch_offset,
    input  logic [8:0]      mach_code,
    output logic [D-1:0]    prog_ctr,
    output logic [8:0]      instr,
    output logic            instr_valid,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] instr_count
);
    fetch_state_t    state, state_nxt;
    logic [D-1:0]    pc, pc_nxt, pc_calc;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic            is_halt;

    assign is_halt = (mach_code == HALT_CODE);

    pc_next_calc #(
        .D    (D),
        .OFFW (OFFW)
    ) u_pc_next_calc (
        .pc      (pc),
        .taken   (branch_taken),
        .abs     (branch_abs),
        .target  (branch_target),
        .offset  (branch_offset),
        .next_pc (pc_calc)
    );

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        if (!stall) begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt = RUN;
                        pc_nxt    = START_ADDR;
                        cnt_nxt   = '0;
                    end
                end
                RUN: begin
                    // HALT outranks any branch request issued alongside it.
                    if (is_halt) begin
                        state_nxt = DONE;
                    end else begin
                        pc_nxt = pc_calc;
                        if (cnt != '1) begin
                            cnt_nxt = cnt + CNTW'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pc    <= START_ADDR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign prog_ctr    = pc;
    assign instr       = mach_code;
    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign instr_valid = busy && !stall && !is_halt;
    assign instr_count = cnt;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random stimulus against a behavioural model.
module tb_fetch_sequencer;
    localparam int ROM_DEPTH = 4096;
    localparam logic [8:0] HALT = 9'h1FF;
    localparam logic [8:0] ADD  = 9'h001;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic        branch_abs;
    logic [11:0] branch_target;
    logic [7:0]  branch_offset;
    logic [8:0]  mach_code;
    logic [11:0] prog_ctr;
    logic [8:0]  instr;
    logic        instr_valid;
    logic        busy;
    logic        done;
    logic [15:0] instr_count;

    logic [8:0] rom [0:ROM_DEPTH-1];

    int total = 0;
    int bad   = 0;

    // Reference model state: plain integers and flags.
    int m_pc;
    int m_cnt;
    bit m_running;
    bit m_finished;

    fetch_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_abs    (branch_abs),
        .branch_target (branch_target),
        .branch_offset (branch_offset),
        .mach_code     (mach_code),
        .prog_ctr      (prog_ctr),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .busy          (busy),
        .done          (done),
        .instr_count   (instr_count)
    );

    assign mach_code = rom[prog_ctr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [8:0] word;
        bit         exp_valid;
        word      = rom[m_pc];
        exp_valid = m_running && !stall && (word != HALT);
        check({tag, ".prog_ctr"},    32'(prog_ctr),    32'(m_pc));
        check({tag, ".instr"},       32'(instr),       32'(word));
        check({tag, ".instr_valid"}, 32'(instr_valid), 32'(exp_valid));
        check({tag, ".busy"},        32'(busy),        32'(m_running));
        check({tag, ".done"},        32'(done),        32'(m_finished));
        check({tag, ".instr_count"}, 32'(instr_count), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_pc       = 0;
        m_cnt      = 0;
        m_running  = 0;
        m_finished = 0;
    endtask

    task automatic model_step();
        if (stall) return;
        if (m_running) begin
            if (rom[m_pc] == HALT) begin
                m_running  = 0;
                m_finished = 1;
            end else begin
                if (m_cnt < 65535) m_cnt++;
                if (branch_taken && branch_abs)
                    m_pc = int'(branch_target);
                else if (branch_taken)
                    m_pc = ((m_pc + int'($signed(branch_offset))) % ROM_DEPTH + ROM_DEPTH) % ROM_DEPTH;
                else
                    m_pc = (m_pc + 1) % ROM_DEPTH;
            end
        end else if (start) begin
            m_running  = 1;
            m_finished = 0;
            m_pc       = 0;
            m_cnt      = 0;
        end
    endtask

    task automatic set_in(input bit st, input bit sl, input bit tk, input bit ab,
                          input logic [11:0] tg, input logic [7:0] of);
        start         = st;
        stall         = sl;
        branch_taken  = tk;
        branch_abs    = ab;
        branch_target = tg;
        branch_offset = of;
    endtask

    // Inputs are set just after a rising edge; outputs are sampled 1ns later, mid-cycle.
    task automatic tick(input string tag);
        #1;
        check_all(tag);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < ROM_DEPTH; i++) rom[i] = ADD;
        set_in(0, 0, 0, 0, 12'h000, 8'h00);
        reset_n = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset mid-run at PC 5 aborts immediately.
        set_in(1, 0, 0, 0, 12'h000, 8'h00);
        tick("t1_start");
        set_in(0, 0, 0, 0, 12'h000, 8'h00);
        for (int i = 0; i < 5; i++) tick("t1_run");
        check("t1_pc_before_reset", 32'(prog_ctr), 32'h005);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t1_async_pc", 32'(prog_ctr), 32'h000);
        check("t1_async_busy", 32'(busy), 32'h0);
        check("t1_async_count", 32'(instr_count), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick("t1_idle");
        check("t1_still_idle", 32'(busy), 32'h0);

        // Straight-line run into HALT at address 4.
        rom[4] = HALT;
        set_in(1, 0, 0, 0, 12'h000, 8'h00);
        tick("t2_start");
        set_in(0, 0, 0, 0, 12'h000, 8'h00);
        for (int i = 0; i < 5; i++) begin
            check("t2_seq_pc", 32'(prog_ctr), 32'(i));
            tick("t2_run");
        end
        check("t2_done", 32'(done), 32'h1);
        check("t2_count", 32'(instr_count), 32'd4);
        tick("t2_hold");
        check("t2_pc_hold", 32'(prog_ctr), 32'h004);
        rom[4] = ADD;

        // Relative branches (including wrap below zero), then sequential wrap and absolute branch.
        rom[12'h125] = HALT;
        set_in(1, 0, 0, 0, 12'h000, 8'h00);
        tick("t3_restart");
        set_in(1, 0, 1, 1, 12'h010, 8'h00);
        tick("t3_abs_with_start");
        check("t3_start_in_run_ignored", 32'(prog_ctr), 32'h010);
        set_in(0, 0, 1, 0, 12'h000, 8'hFD);
        tick("t3_rel_m3");
        check("t3_rel_m3_pc", 32'(prog_ctr), 32'h00D);
        set_in(0, 0, 1, 1, 12'h000, 8'h00);
        tick("t3_abs0");
        set_in(0, 0, 1, 0, 12'h000, 8'hFF);
        tick("t3_rel_m1");
        check("t3_rel_wrap_pc", 32'(prog_ctr), 32'hFFF);
        set_in(0, 0, 0, 0, 12'h000, 8'h00);
        tick("t4_seq_wrap");
        check("t4_seq_wrap_pc", 32'(prog_ctr), 32'h000);
        set_in(0, 0, 1, 1, 12'h123, 8'h00);
        tick("t4_abs");
        check("t4_abs_pc", 32'(prog_ctr), 32'h123);

        // Stall with a pending branch: nothing moves, branch is dropped.
        set_in(0, 1, 1, 1, 12'h555, 8'h00);
        for (int i = 0; i < 3; i++) tick("t5_stall");
        check("t5_frozen_pc", 32'(prog_ctr), 32'h123);
        check("t5_frozen_count", 32'(instr_count), 32'd6);
        set_in(0, 0, 0, 0, 12'h000, 8'h00);
        tick("t5_resume");
        check("t5_after_pc", 32'(prog_ctr), 32'h124);
        check("t5_after_count", 32'(instr_count), 32'd7);

        // HALT beats a simultaneous branch; start from DONE restarts cleanly.
        tick("t6_to_halt");
        set_in(0, 0, 1, 1, 12'h000, 8'h00);
        tick("t6_halt_branch");
        check("t6_done", 32'(done), 32'h1);
        check("t6_halt_pc", 32'(prog_ctr), 32'h125);
        check("t6_halt_count", 32'(instr_count), 32'd8);
        set_in(1, 0, 0, 0, 12'h000, 8'h00);
        tick("t6_restart");
        check("t6_restart_pc", 32'(prog_ctr), 32'h000);
        check("t6_restart_count", 32'(instr_count), 32'd0);
        check("t6_restart_done", 32'(done), 32'h0);
        rom[12'h125] = ADD;

        // Counter saturation after more than 2**16-1 retirements.
        set_in(0, 0, 0, 0, 12'h000, 8'h00);
        for (int i = 0; i < 65540; i++) tick("sat");
        check("sat_count", 32'(instr_count), 32'h0000FFFF);

        // Random programs and control traffic.
        for (int i = 0; i < ROM_DEPTH; i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? HALT : 9'($urandom_range(0, 510));
        for (int n = 0; n < 3000; n++) begin
            logic s;
            s = ($urandom_range(0, 3) == 0);
            set_in(!s && ($urandom_range(0, 7) == 0), s,
                   ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                   12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
